// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter and access sequencer for the single-ported memory model.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic        port_d_r;
    logic        if_rsp_valid_r;
    logic [31:0] if_rsp_data_r;
    logic        if_rsp_err_r;
    logic        d_rsp_valid_r;
    logic [31:0] d_rsp_data_r;
    logic        d_rsp_err_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        busy_r;
`ifdef MEM_ARB_RR_EN
    logic        last_d_r;
`endif

    logic        grant_d_s;
    logic        grant_i_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_we_s;

    // Grant selection; only possible while idle.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (state_r == IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (d_req_valid && if_req_valid) begin
                grant_d_s = ~last_d_r;
                grant_i_s = last_d_r;
            end else begin
                grant_d_s = d_req_valid;
                grant_i_s = if_req_valid;
            end
`else
            grant_d_s = d_req_valid;
            grant_i_s = if_req_valid & ~d_req_valid;
`endif
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Payload of the winning port; fetch is always a read.
    always_comb begin
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        sel_we_s    = 1'b0;
        if (grant_d_s) begin
            sel_addr_s  = d_req_addr;
            sel_wdata_s = d_req_wdata;
            sel_we_s    = d_req_we;
        end else begin
            sel_addr_s  = if_req_addr;
            sel_wdata_s = 32'd0;
            sel_we_s    = 1'b0;
        end
    end

    // Request FSM with all memory and response outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            cnt_r          <= 4'd0;
            we_r           <= 1'b0;
            port_d_r       <= 1'b0;
            if_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= 32'd0;
            if_rsp_err_r   <= 1'b0;
            d_rsp_valid_r  <= 1'b0;
            d_rsp_data_r   <= 32'd0;
            d_rsp_err_r    <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= 32'd0;
            mem_wdata_r    <= 32'd0;
            busy_r         <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_r       <= 1'b0;
`endif
        end else begin
            if_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= 32'd0;
            if_rsp_err_r   <= 1'b0;
            d_rsp_valid_r  <= 1'b0;
            d_rsp_data_r   <= 32'd0;
            d_rsp_err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_d_s || grant_i_s) begin
                        port_d_r <= grant_d_s;
                        we_r     <= sel_we_s;
                        busy_r   <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_d_r <= grant_d_s;
`endif
                        // Misaligned: answer with an error, never touch memory.
                        if (sel_addr_s[1:0] != 2'b00) begin
                            state_r <= RESP;
                            if (grant_d_s) begin
                                d_rsp_valid_r <= 1'b1;
                                d_rsp_err_r   <= 1'b1;
                            end else begin
                                if_rsp_valid_r <= 1'b1;
                                if_rsp_err_r   <= 1'b1;
                            end
                        end else begin
                            state_r     <= ACCESS;
                            cnt_r       <= LAT_M1;
                            mem_addr_r  <= sel_addr_s;
                            mem_wdata_r <= sel_wdata_s;
                            mem_we_r    <= sel_we_s && (LAT_M1 == 4'd0);
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r    <= cnt_r - 4'd1;
                        mem_we_r <= we_r && (cnt_r == 4'd1);
                    end else begin
                        state_r     <= RESP;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= 32'd0;
                        mem_wdata_r <= 32'd0;
                        if (port_d_r) begin
                            d_rsp_valid_r <= 1'b1;
                            d_rsp_data_r  <= we_r ? 32'd0 : mem_rdata;
                            d_rsp_err_r   <= mem_err;
                        end else begin
                            if_rsp_valid_r <= 1'b1;
                            if_rsp_data_r  <= mem_rdata;
                            if_rsp_err_r   <= mem_err;
                        end
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= 32'd0;
                    mem_wdata_r <= 32'd0;
                end
            endcase
        end
    end

    assign if_req_ready = grant_i_s;
    assign d_req_ready  = grant_d_s;
    assign if_rsp_valid = if_rsp_valid_r;
    assign if_rsp_data  = if_rsp_data_r;
    assign if_rsp_err   = if_rsp_err_r;
    assign d_rsp_valid  = d_rsp_valid_r;
    assign d_rsp_data   = d_rsp_data_r;
    assign d_rsp_err    = d_rsp_err_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign busy         = busy_r;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported simulated memory of the MIPS32 pipeline. It accepts read requests from instruction fetch and read/write requests from the data stage, grants one at a time, and drives the memory's write-enable, address and write-data for a configurable number of cycles. It returns a one-cycle response pulse with data and error status to the winning requester. It sits between the IF/MEM pipeline stages and the memory model.

## Interface
- `LATENCY`, default 1: access cycles per request, legal range 1..15.
- `clk` in 1: clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `if_req_valid` in 1: fetch read request.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_req_addr` in 32: fetch byte address.
- `if_rsp_valid` out 1: one-cycle fetch response pulse.
- `if_rsp_data` out 32: fetch read data.
- `if_rsp_err` out 1: fetch error.
- `d_req_valid` in 1: data request.
- `d_req_ready` out 1: data request accepted this cycle.
- `d_req_we` in 1: 1 = write, 0 = read.
- `d_req_addr` in 32: data byte address.
- `d_req_wdata` in 32: write data.
- `d_rsp_valid` out 1: one-cycle data response pulse.
- `d_rsp_data` out 32: read data; 0 for writes.
- `d_rsp_err` out 1: data error.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.
- `mem_err` in 1: memory error flag.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `*_req_valid` is high, select a winner and assert only the winner's `*_req_ready`. Ready is combinational and is never high outside IDLE.
  - On the handshake edge, latch addr, we, wdata and port ID.
  - If the latched addr[1:0] != 0, go to RESP with err=1 and data=0. No memory access is made.
  - Otherwise load the counter with LATENCY-1 and go to ACCESS.
- ACCESS:
  - Drive `mem_addr` and `mem_wdata` from the latch.
  - `mem_we` = latched we AND (counter == 0), giving exactly one write pulse per write.
  - While counter != 0, decrement it.
  - When counter == 0: capture rsp_data (`mem_rdata` for reads, 0 for writes) and err (`mem_err`), then go to RESP.
- RESP:
  - Assert the winner's `*_rsp_valid` for exactly one cycle, with the registered data and err on that port.
  - The other port's rsp outputs are 0.
  - Go to IDLE.
- Outside ACCESS, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- Fetch requests are always reads. The data port supports both reads and writes.
- A requester keeps valid and payload stable until it sees ready. A request that is dropped before ready is never served.

## Timing
- Handshake in cycle T0. ACCESS occupies T1..T(LATENCY). rsp_valid is high in T(LATENCY+1). Next grant is possible at T(LATENCY+2).
- Misaligned request: rsp_valid in T1 with err=1. Next grant at T2.
- Throughput: one request per LATENCY+2 cycles.
- Reset values: all outputs 0, state IDLE, counter 0, round-robin pointer set so the data port has priority.
- Reset asserted mid-operation: abort immediately. `mem_we` drops asynchronously, no response is issued, and the latched request is discarded.
- Requests arriving while busy are held off by ready=0. The requester must hold valid.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When both ports are valid in IDLE, the port not granted last wins. With a single valid port, that port wins.
- `MEM_ARB_RR_EN` undefined: fixed priority, data port always wins over fetch. Fetch can be starved while `d_req_valid` stays high.

## Test plan
- LATENCY=1, fetch read 0x100 with `mem_rdata`=0xDEADBEEF -> `if_req_ready` high at T0, `mem_addr`=0x100 at T1, `if_rsp_valid`=1 with data 0xDEADBEEF and err 0 at T2.
- Data write addr 0x200, wdata 0x12345678 -> `mem_we`=1 for exactly one cycle (T1) with matching addr/wdata, then `d_rsp_valid`=1, data 0, err 0.
- Both ports valid continuously for 4 grants -> without macro: D,D,D,D and no `if_rsp_valid`; with `MEM_ARB_RR_EN`: D,I,D,I.
- Data write to 0x203 -> `mem_we` never asserted, `d_rsp_valid`=1 with err=1 at T1, `busy` low at T2.
- LATENCY=3, data read 0x40 with `mem_err`=1 in the last ACCESS cycle -> `d_rsp_valid` at T4, `d_rsp_err`=1.
- LATENCY=3, data write, `reset_n` pulled low at T2 -> all outputs 0 immediately, no `mem_we` pulse, no response; a fetch issued after reset completes normally.
